// File: rtl/ap_com_tt_scan.sv
// Truth-table scanner: sweeps every input vector into an ap_com_* cell, captures its
// output table and counts the bits that disagree with a latched reference table.
module ap_com_tt_scan #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   ref_tt,
    output logic [N_IN-1:0]      dut_in,
    input  logic                 dut_y,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   tt_out,
    output logic [N_IN:0]        err_cnt,
    output logic                 match
);
    localparam int NV = 2**N_IN;
    localparam logic [3:0] SETTLE_L = 4'(SETTLE);

    typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

    state_t            state, state_nx;
    logic [NV-1:0]     ref_q;
    logic [N_IN-1:0]   vec;
    logic [3:0]        settle_cnt;
    logic              sample, last, miss;
    logic [N_IN:0]     err_nx;

    // The vector index drives the cell directly; incrementing past the last
    // vector naturally returns it to 0 as the scan closes.
    assign dut_in = vec;
    assign sample = (state == SCAN) && (settle_cnt == SETTLE_L);
    assign last   = sample && (&vec);
    assign miss   = dut_y ^ ref_q[vec];
    assign err_nx = err_cnt + {{N_IN{1'b0}}, miss};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SCAN;
            SCAN:    if (last)  state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_q      <= '0;
            vec        <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            tt_out     <= '0;
            err_cnt    <= '0;
            match      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ref_q      <= ref_tt;
                        tt_out     <= '0;
                        err_cnt    <= '0;
                        match      <= 1'b0;
                        vec        <= '0;
                        settle_cnt <= '0;
                        busy       <= 1'b1;
                    end
                end
                SCAN: begin
                    if (sample) begin
                        tt_out[vec] <= dut_y;
                        err_cnt     <= err_nx;
                        vec         <= vec + 1'b1;
                        settle_cnt  <= '0;
                        if (&vec) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            match <= (err_nx == '0);
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                FIN:     done <= 1'b0;
                default: done <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_ap_com_tt_scan.sv
// Directed bench for ap_com_tt_scan: four instances cover the parameter sets,
// each driving a small behavioural compressor cell.
module tb_ap_com_tt_scan;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // N_IN=4, SETTLE=0 : index_0 style carry cell
    logic        st4 = 1'b0;
    logic [15:0] ref4 = '0;
    logic [3:0]  din4;
    logic        y4, busy4, done4, match4;
    logic [15:0] tt4;
    logic [4:0]  err4;
    assign y4 = (din4[1] & din4[0]) | ((din4[3] | din4[2]) & (din4[1] | din4[0]));

    // N_IN=2, SETTLE=0 : XNOR cell
    logic        st2 = 1'b0;
    logic [3:0]  ref2 = '0;
    logic [1:0]  din2;
    logic        y2, busy2, done2, match2;
    logic [3:0]  tt2;
    logic [2:0]  err2;
    assign y2 = ~(din2[1] ^ din2[0]);

    // N_IN=2, SETTLE=2 : pass-through of input b
    logic        st2s = 1'b0;
    logic [3:0]  ref2s = '0;
    logic [1:0]  din2s;
    logic        y2s, busy2s, done2s, match2s;
    logic [3:0]  tt2s;
    logic [2:0]  err2s;
    assign y2s = din2s[0];

    // N_IN=3, SETTLE=0 : majority cell
    logic        st3 = 1'b0;
    logic [7:0]  ref3 = '0;
    logic [2:0]  din3;
    logic        y3, busy3, done3, match3;
    logic [7:0]  tt3;
    logic [3:0]  err3;
    assign y3 = (din3[2] & din3[1]) | (din3[2] & din3[0]) | (din3[1] & din3[0]);

    ap_com_tt_scan #(.N_IN(4), .SETTLE(0)) u4 (
        .clk(clk), .rst(rst), .start(st4), .ref_tt(ref4), .dut_in(din4), .dut_y(y4),
        .busy(busy4), .done(done4), .tt_out(tt4), .err_cnt(err4), .match(match4));
    ap_com_tt_scan #(.N_IN(2), .SETTLE(0)) u2 (
        .clk(clk), .rst(rst), .start(st2), .ref_tt(ref2), .dut_in(din2), .dut_y(y2),
        .busy(busy2), .done(done2), .tt_out(tt2), .err_cnt(err2), .match(match2));
    ap_com_tt_scan #(.N_IN(2), .SETTLE(2)) u2s (
        .clk(clk), .rst(rst), .start(st2s), .ref_tt(ref2s), .dut_in(din2s), .dut_y(y2s),
        .busy(busy2s), .done(done2s), .tt_out(tt2s), .err_cnt(err2s), .match(match2s));
    ap_com_tt_scan #(.N_IN(3), .SETTLE(0)) u3 (
        .clk(clk), .rst(rst), .start(st3), .ref_tt(ref3), .dut_in(din3), .dut_y(y3),
        .busy(busy3), .done(done3), .tt_out(tt3), .err_cnt(err3), .match(match3));

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({din4, busy4, done4, tt4, err4, match4} !== '0) begin
            n_err++; $display("FAIL reset_u4: got %h want 0", {din4, busy4, done4, tt4, err4, match4});
        end
        n_cmp++;
        if ({din2, busy2, done2, tt2, err2, match2} !== '0) begin
            n_err++; $display("FAIL reset_u2: got %h want 0", {din2, busy2, done2, tt2, err2, match2});
        end
        n_cmp++;
        if ({din2s, busy2s, done2s, tt2s, err2s, match2s} !== '0) begin
            n_err++; $display("FAIL reset_u2s: got %h want 0", {din2s, busy2s, done2s, tt2s, err2s, match2s});
        end
        n_cmp++;
        if ({din3, busy3, done3, tt3, err3, match3} !== '0) begin
            n_err++; $display("FAIL reset_u3: got %h want 0", {din3, busy3, done3, tt3, err3, match3});
        end
        rst = 1'b0;
        tick();
    endtask

    // Cell table 16'hEEE8 against reference 16'hFEE8: only vector 12 differs.
    task automatic test_majority4();
        ref4 = 16'hFEE8;
        st4  = 1'b1;
        tick();
        st4  = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            n_cmp++;
            if (busy4 !== (c <= 16)) begin
                n_err++; $display("FAIL maj4_busy c%0d: got %b want %b", c, busy4, (c <= 16));
            end
            n_cmp++;
            if (done4 !== (c == 17)) begin
                n_err++; $display("FAIL maj4_done c%0d: got %b want %b", c, done4, (c == 17));
            end
            if (c <= 16) begin
                n_cmp++;
                if (din4 !== 4'(c - 1)) begin
                    n_err++; $display("FAIL maj4_dut_in c%0d: got %0d want %0d", c, din4, c - 1);
                end
            end
            if (c == 17) begin
                n_cmp++;
                if (tt4 !== 16'hEEE8) begin
                    n_err++; $display("FAIL maj4_tt: got %h want eee8", tt4);
                end
                n_cmp++;
                if (err4 !== 5'd1) begin
                    n_err++; $display("FAIL maj4_err: got %0d want 1", err4);
                end
                n_cmp++;
                if (match4 !== 1'b0) begin
                    n_err++; $display("FAIL maj4_match: got %b want 0", match4);
                end
            end
            tick();
        end
    endtask

    // XNOR (4'h9) against XOR (4'h6): every bit wrong, err_cnt reaches 4.
    task automatic test_xnor2();
        ref2 = 4'h6;
        st2  = 1'b1;
        tick();
        st2  = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            n_cmp++;
            if (done2 !== (c == 5)) begin
                n_err++; $display("FAIL xnor_done c%0d: got %b want %b", c, done2, (c == 5));
            end
            if (c == 5) begin
                n_cmp++;
                if (tt2 !== 4'h9) begin
                    n_err++; $display("FAIL xnor_tt: got %h want 9", tt2);
                end
                n_cmp++;
                if (err2 !== 3'd4) begin
                    n_err++; $display("FAIL xnor_err: got %0d want 4", err2);
                end
                n_cmp++;
                if (match2 !== 1'b0) begin
                    n_err++; $display("FAIL xnor_match: got %b want 0", match2);
                end
            end
            tick();
        end
        // values must persist while idle
        n_cmp++;
        if ({tt2, err2} !== {4'h9, 3'd4}) begin
            n_err++; $display("FAIL xnor_hold: got %h/%0d want 9/4", tt2, err2);
        end
    endtask

    task automatic test_settle();
        ref2s = 4'hA;
        st2s  = 1'b1;
        tick();
        st2s  = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            if (c <= 12) begin
                n_cmp++;
                if (din2s !== 2'((c - 1) / 3)) begin
                    n_err++; $display("FAIL settle_dut_in c%0d: got %0d want %0d", c, din2s, (c - 1) / 3);
                end
            end
            n_cmp++;
            if (done2s !== (c == 13)) begin
                n_err++; $display("FAIL settle_done c%0d: got %b want %b", c, done2s, (c == 13));
            end
            if (c == 13) begin
                n_cmp++;
                if ({tt2s, err2s, match2s} !== {4'hA, 3'd0, 1'b1}) begin
                    n_err++; $display("FAIL settle_result: got tt=%h err=%0d m=%b want tt=a err=0 m=1", tt2s, err2s, match2s);
                end
                n_cmp++;
                if (din2s !== 2'd0) begin
                    n_err++; $display("FAIL settle_wrap: got %0d want 0", din2s);
                end
            end
            tick();
        end
    endtask

    task automatic test_ignored_inputs();
        int ndone = 0;
        ref3 = 8'hE8;
        st3  = 1'b1;
        tick();
        st3  = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            if (c == 4) begin
                st3  = 1'b1;
                ref3 = 8'h00;
            end
            if (c == 5) st3 = 1'b0;
            if (done3) ndone++;
            n_cmp++;
            if (busy3 !== (c <= 8)) begin
                n_err++; $display("FAIL ign_busy c%0d: got %b want %b", c, busy3, (c <= 8));
            end
            if (c == 9) begin
                n_cmp++;
                if ({done3, tt3, err3, match3} !== {1'b1, 8'hE8, 4'd0, 1'b1}) begin
                    n_err++; $display("FAIL ign_result: got d=%b tt=%h err=%0d m=%b want d=1 tt=e8 err=0 m=1", done3, tt3, err3, match3);
                end
            end
            tick();
        end
        n_cmp++;
        if (ndone !== 1) begin
            n_err++; $display("FAIL ign_done_count: got %0d want 1", ndone);
        end
    endtask

    task automatic test_reset_mid();
        int ndone = 0;
        ref4 = 16'hFEE8;
        st4  = 1'b1;
        tick();
        st4  = 1'b0;
        tick(); tick(); tick(); tick();
        rst = 1'b1;             // now in cycle 5
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({din4, busy4, done4, tt4, err4, match4} !== '0) begin
            n_err++; $display("FAIL rstmid_outputs: got %h want 0", {din4, busy4, done4, tt4, err4, match4});
        end
        for (int c = 0; c < 20; c++) begin
            if (done4 || busy4) ndone++;
            tick();
        end
        n_cmp++;
        if (ndone !== 0) begin
            n_err++; $display("FAIL rstmid_activity: got %0d want 0", ndone);
        end
        test_majority4();
    endtask

    task automatic test_back_to_back();
        ref2 = 4'h6;
        st2  = 1'b1;
        tick();
        for (int c = 1; c <= 14; c++) begin
            n_cmp++;
            if (busy2 !== (((c - 1) % 6) < 4)) begin
                n_err++; $display("FAIL b2b_busy c%0d: got %b want %b", c, busy2, (((c - 1) % 6) < 4));
            end
            n_cmp++;
            if (done2 !== ((c % 6) == 5)) begin
                n_err++; $display("FAIL b2b_done c%0d: got %b want %b", c, done2, ((c % 6) == 5));
            end
            if (c == 5 || c == 11) begin
                n_cmp++;
                if ({tt2, err2} !== {4'h9, 3'd4}) begin
                    n_err++; $display("FAIL b2b_result c%0d: got %h/%0d want 9/4", c, tt2, err2);
                end
            end
            if (c == 7) begin
                n_cmp++;
                if ({tt2, err2} !== {4'h0, 3'd0}) begin
                    n_err++; $display("FAIL b2b_clear: got %h/%0d want 0/0", tt2, err2);
                end
            end
            tick();
        end
        st2 = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        n_cmp++;
        if ({busy2, done2} !== 2'b00) begin
            n_err++; $display("FAIL b2b_stop: got %b want 00", {busy2, done2});
        end
    endtask

    initial begin
        test_reset();
        test_majority4();
        test_xnor2();
        test_settle();
        test_ignored_inputs();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ap_com_tt_scan.md
# ap_com_tt_scan

Sequential truth-table scanner for the approximate compressor cells. It sweeps every input combination into a combinational (or shallowly registered) `ap_com_*` cell under test and captures the cell's output into a truth-table word. It also compares that word against a reference table and reports the Hamming error count. It sits beside the compressor library in the multiplier test harness, reading back what the evolutionary flow wrote into each cell.

## Interface
- Reset is synchronous and active-high; there is a single clock.
- Parameters:
  - `N_IN`, default 4: number of cell inputs; legal values 2, 3, 4.
  - `SETTLE`, default 0: extra hold cycles per vector before sampling; legal range 0..15.
- Ports:
  - `clk` in, 1: single clock; everything changes on the rising edge.
  - `rst` in, 1: synchronous, active-high reset.
  - `start` in, 1: begin a scan; honoured only in IDLE.
  - `ref_tt` in, 2^N_IN: reference table; bit v is the expected y for vector v; latched on start.
  - `dut_in` out, N_IN: vector driven to the cell; bit N_IN-1 maps to input `a` (MSB of the case index) and bit 0 maps to the last input.
  - `dut_y` in, 1: cell output.
  - `busy` out, 1: a scan is in progress.
  - `done` out, 1: one-cycle pulse after the final sample.
  - `tt_out` out, 2^N_IN: captured table; bit v holds y sampled for vector v.
  - `err_cnt` out, N_IN+1: popcount of `tt_out ^ ref_tt_latched`.
  - `match` out, 1: high when `err_cnt` is 0; valid from `done` onward.

## Operation
- States and transitions:
  - IDLE goes to SCAN on `start`.
  - SCAN goes to FIN after the last vector is sampled.
  - FIN goes to IDLE unconditionally, after one cycle.
- Reset values: state IDLE, `dut_in` 0, `busy` 0, `done` 0, `tt_out` 0, `err_cnt` 0, `match` 0, vector index 0, settle counter 0.
- When `start` is accepted in IDLE:
  - latch `ref_tt`;
  - clear `tt_out` and `err_cnt`;
  - set vector index v = 0 and `dut_in` = 0;
  - set `busy` = 1.
- SCAN, per vector:
  - Hold `dut_in` = v for SETTLE+1 cycles.
  - On the last of those cycles' edges, write `dut_y` into `tt_out[v]`.
  - In the same edge, increment `err_cnt` if `dut_y` differs from `ref_latched[v]`.
  - Then advance v and reset the settle counter.
- Vector order is ascending 0 .. 2^N_IN-1, with no gaps or repeats.
- Wrap-around: after v = 2^N_IN-1 is sampled, `dut_in` returns to 0 and the block enters FIN; the index does not wrap into a second pass.
- FIN: `done` = 1 and `busy` = 0 for exactly one cycle; `match` is updated.
- `tt_out`, `err_cnt` and `match` hold their values until the next accepted `start` or `rst`.
- Boundary conditions:
  - `start` while `busy` or in FIN: ignored, with no effect on the scan or on the latched reference.
  - `start` held high continuously: a new scan begins in the IDLE cycle after FIN, so scans run back to back with one idle cycle between them.
  - Changes on `ref_tt` mid-scan: ignored.
  - `rst` mid-scan: aborts the scan immediately; all outputs return to reset values on that edge and no `done` is issued.
  - `err_cnt` range: it counts to at most 2^N_IN, which fits in N_IN+1 bits; the count never saturates or wraps.

## Timing
- The `start` edge is edge 0.
- Vector v is driven during cycles 1 + v(SETTLE+1) through (v+1)(SETTLE+1).
- Its sample is taken on the closing edge of that window.
- `busy` is high for 2^N_IN·(SETTLE+1) cycles.
- `done` is high in cycle 2^N_IN·(SETTLE+1)+1.
- A new `start` is accepted from the following cycle.
- `dut_y` must be stable within SETTLE+1 cycles of a `dut_in` change. With SETTLE = 0, the cell must be purely combinational.
- `err_cnt` is accumulated incrementally, so it is final in the same cycle that `done` is high.

## Test plan
- 4-input majority-carry check: `N_IN`=4, `SETTLE`=0, DUT = index_0 function (1 at vectors 3,5,6,7,9,10,11,13,14,15), `ref_tt`=16'hFEE8.
  - Required: `tt_out`=16'hEEE8, `err_cnt`=1, `match`=0, `done` in cycle 17, `busy` high in cycles 1–16.
- 2-input XNOR vs XOR: `N_IN`=2, DUT = XNOR (index_13 function), `ref_tt`=4'h6.
  - Required: `tt_out`=4'h9, `err_cnt`=4 (saturation width check), `match`=0.
- Settle and ordering: `N_IN`=2, `SETTLE`=2, DUT = `b`, `ref_tt`=4'hA.
  - Required: `dut_in` sequence 0,0,0,1,1,1,2,2,2,3,3,3 in cycles 1–12, `done` in cycle 13, `tt_out`=4'hA, `match`=1.
- Ignored inputs mid-scan: `N_IN`=3, pulse `start` and change `ref_tt` in cycle 4.
  - Required: scan timing unchanged, comparison uses the reference latched at cycle 0, and exactly one `done`.
- Reset mid-scan: assert `rst` in cycle 5 of a 4-input scan.
  - Required: next cycle shows all outputs at 0, no `done`; a following `start` completes a normal full scan.
- Back-to-back scans: hold `start` high.
  - Required: scans repeat with one IDLE cycle between `done` and the next `busy`, and `tt_out` is cleared at each restart.
